// File: rtl/cpu_pkg.sv
// Shared types and encodings for the simple-RISC multi-cycle controller.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_RST, IF1, IF2, UPC, EXEC, LDR1, LDR2, STR, HALT
    } state_t;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_PLAIN   = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_ALU   = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [1:0]  sh;
        logic [2:0]  rm;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } instr_t;

endpackage

// File: rtl/instr_decoder.sv
// Splits the instruction register into its fields and sign-extends the immediates.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output instr_t      dec
);

    always_comb begin
        dec.opcode = ir[15:13];
        dec.op     = ir[12:11];
        dec.rn     = ir[10:8];
        dec.rd     = ir[7:5];
        dec.sh     = ir[4:3];
        dec.rm     = ir[2:0];
        dec.sximm5 = {{11{ir[4]}}, ir[4:0]};
        dec.sximm8 = {{8{ir[7]}}, ir[7:0]};
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer; owns PC, IR and the data-address register.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] datapath_out,
    output logic [1:0]  mem_cmd,
    output logic [7:0]  mem_addr,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [2:0]  readA,
    output logic [2:0]  readB,
    output logic [2:0]  writenum,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic [7:0]  PC,
    output logic        halted
);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  addr_q, addr_d;
    instr_t      dec;

    // Only the low byte of the ALU result forms a memory address.
    logic unused_dp_hi;
    assign unused_dp_hi = ^datapath_out[15:8];

    instr_decoder u_dec (
        .ir  (ir_q),
        .dec (dec)
    );

    assign PC     = pc_q;
    assign sximm5 = dec.sximm5;
    assign sximm8 = dec.sximm8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        mem_cmd  = MEM_NONE;
        mem_addr = pc_q;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        write    = 1'b0;
        vsel     = VSEL_ALU;
        ALUop    = 2'b00;
        shift    = 2'b00;
        readA    = 3'd0;
        readB    = 3'd0;
        writenum = 3'd0;
        halted   = 1'b0;

        case (state_q)
            S_RST: state_d = IF1;
            IF1: begin
                mem_cmd = MEM_READ;
                state_d = IF2;
            end
            IF2: begin
                mem_cmd = MEM_READ;
                ir_d    = mem_rdata;
                state_d = UPC;
            end
            UPC: begin
                pc_d    = pc_q + 8'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = IF1;
                case (dec.opcode)
                    OPC_MOV: begin
                        if (dec.op == OP_MOV_IMM) begin
                            vsel     = VSEL_IMM8;
                            writenum = dec.rn;
                            write    = 1'b1;
                        end else if (dec.op == OP_MOV_REG) begin
                            asel     = 1'b1;
                            readB    = dec.rm;
                            shift    = dec.sh;
                            writenum = dec.rd;
                            write    = 1'b1;
                        end
                    end
                    OPC_ALU: begin
                        readA = dec.rn;
                        readB = dec.rm;
                        shift = dec.sh;
                        ALUop = dec.op;
                        if (dec.op == OP_CMP) begin
                            loads = 1'b1;
                        end else begin
                            writenum = dec.rd;
                            write    = 1'b1;
                        end
                    end
                    OPC_LDR, OPC_STR: begin
                        if (dec.op == OP_PLAIN) begin
                            readA   = dec.rn;
                            bsel    = 1'b1;
                            addr_d  = datapath_out[7:0];
                            state_d = (dec.opcode == OPC_LDR) ? LDR1 : STR;
                        end
                    end
                    OPC_HALT: begin
                        if (dec.op == OP_PLAIN) state_d = HALT;
                    end
                    default: ;
                endcase
            end
            LDR1: begin
                mem_cmd  = MEM_READ;
                mem_addr = addr_q;
                state_d  = LDR2;
            end
            LDR2: begin
                mem_cmd  = MEM_READ;
                mem_addr = addr_q;
                vsel     = VSEL_MDATA;
                writenum = dec.rd;
                write    = 1'b1;
                state_d  = IF1;
            end
            STR: begin
                // Rd is routed through the shifter/ALU unchanged so it lands on datapath_out.
                mem_cmd  = MEM_WRITE;
                mem_addr = addr_q;
                readB    = dec.rd;
                asel     = 1'b1;
                state_d  = IF1;
            end
            HALT: halted = 1'b1;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Multi-cycle sequencer for the simple-RISC datapath (regfile, shifter, ALU, status register, vsel/asel/bsel muxes). It fetches 16-bit instructions from a 256-word memory and holds them in an internal IR. It decodes each instruction and drives every datapath control input for one execute cycle, plus extra memory cycles for LDR/STR. It owns the PC and the data-address register.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
mem_rdata  in  16  memory read data; valid in the 2nd consecutive READ cycle at the same address
datapath_out  in  16  ALU result from datapath; captured for LDR/STR address
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
mem_addr  out  8  memory address
loads  out  1  status-register enable
asel  out  1  1 = A operand forced to 0
bsel  out  1  1 = B operand is sximm5
write  out  1  regfile write enable
vsel  out  2  00 ALU, 01 PC, 10 sximm8, 11 mdata
ALUop  out  2  ALU operation
shift  out  2  shifter control
readA  out  3  regfile read port A
readB  out  3  regfile read port B
writenum  out  3  regfile write register
sximm5  out  16  sign-extended IR[4:0]
sximm8  out  16  sign-extended IR[7:0]
PC  out  8  program counter
halted  out  1  1 while in HALT

Behaviour:
- Interface as decided: one clock `clk`; reset `rst_n` is asynchronous and active-low. `rst_n`=0 immediately forces:
  - state=S_RST, PC=RESET_PC, IR=0, addr_reg=0.
  - All outputs inactive: mem_cmd=NONE, write=0, loads=0, all selects 0, halted=0.
  - Applies from any state, including mid-LDR or mid-STR.
- Outputs are decoded only from state and IR. There is no combinational path from inputs to outputs.
- IR field layout:
  - opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
  - sximm8 = {8{IR[7]}, IR[7:0]}.
  - sximm5 = {11{IR[4]}, IR[4:0]}.
- Default control in every state unless listed: write=0, loads=0, mem_cmd=NONE, mem_addr=PC.
- States and transitions:
  - S_RST: idle. Next state IF1.
  - IF1: mem_cmd=READ, mem_addr=PC. Next IF2.
  - IF2: mem_cmd=READ, mem_addr=PC; IR<=mem_rdata. Next UPC.
  - UPC: PC<=PC+1, modulo 256 (8'hFF wraps to 8'h00). Next EXEC.
  - EXEC, by instruction:
    - MOV imm (110/10): vsel=10, writenum=Rn, write=1.
    - MOV reg (110/00): asel=1, bsel=0, ALUop=00, readB=Rm, shift=sh, vsel=00, writenum=Rd, write=1.
    - ALU (101/op): readA=Rn, readB=Rm, shift=sh, ALUop=op, asel=0, bsel=0, vsel=00. ADD/AND/MVN: writenum=Rd, write=1. CMP (op=01): loads=1, write=0.
    - LDR (011/00) and STR (100/00): readA=Rn, asel=0, bsel=1, ALUop=00; addr_reg<=datapath_out[7:0]. Next LDR1 or STR.
    - HALT (111/00): next HALT.
    - Any other encoding: treated as NOP, next IF1.
    - All non-memory, non-HALT instructions go to IF1 after EXEC.
  - LDR1: mem_cmd=READ, mem_addr=addr_reg. Next LDR2.
  - LDR2: mem_cmd=READ, mem_addr=addr_reg; vsel=11, writenum=Rd, write=1. Next IF1.
  - STR: mem_cmd=WRITE, mem_addr=addr_reg; readB=Rd, shift=00, asel=1, bsel=0, ALUop=00. Memory writes datapath_out at the clock edge. Next IF1.
  - HALT: halted=1, PC frozen, outputs idle. Exits only by reset.
- Cycle counts from IF1 to the next IF1: MOV/ALU 4, STR 5, LDR 6.

Decomposition:
- Package cpu_pkg:
  - state enum: S_RST, IF1, IF2, UPC, EXEC, LDR1, LDR2, STR, HALT.
  - opcode/op constants.
  - MEM_NONE/READ/WRITE constants.
  - vsel encodings.
- One sub-module, instr_decoder: combinational IR to field extraction and sign extension (sximm5, sximm8).

Test Plan:
1. Reset low mid-run, then release → PC=00, mem_cmd=NONE during reset; first IF1 drives mem_cmd=01, mem_addr=00.
2. MOV R0,#-5 (16'hD0FB) → EXEC: vsel=10, writenum=0, write=1, sximm8=16'hFFFB; PC=01; next IF1 after 4 cycles.
3. ADD R2,R1,R0,LSL#1 (16'hA148) → EXEC: readA=1, readB=0, shift=01, ALUop=00, write=1, writenum=2, loads=0.
   CMP R1,R0 (16'hA900) → loads=1, write=0.
4. LDR R3,[R1,#2] (16'h6162) with datapath_out=16'h0012 → EXEC: bsel=1, sximm5=0002. Then two READ cycles at mem_addr=12. LDR2: vsel=11, writenum=3, write=1. 6 cycles total.
5. STR R3,[R1,#-1] (16'h817F), datapath_out=16'h0010 in EXEC → sximm5=FFFF; STR cycle: mem_cmd=10, mem_addr=10, readB=3, asel=1.
   PC wrap: instruction at 8'hFF → PC becomes 00.
6. HALT (16'hE000) → halted=1 and PC frozen for 20 cycles. Then rst_n=0 asserted during LDR1 → mem_cmd=NONE with no clock edge.
